mpx_stereo_decoder: RTL and testbench

Receive-side counterpart of the stereo MPX composer. It takes 192 kHz composite (MPX) samples together with phase-aligned 38 kHz and 19 kHz reference sines from the local DDS blocks. From these it recovers the left and right channels and flags pilot presence (stereo lock). Two sequential shift-add multiplications per sample share one multiplier sub-module under a small FSM. Outputs feed the downstream channel low-pass filters.

---
 rtl/mpx_stereo_decoder_pkg.sv | 44 ++++
 rtl/mpx_stereo_decoder_seqmult.sv | 68 ++++++
 rtl/mpx_stereo_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_mpx_stereo_decoder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpx_stereo_decoder_pkg.sv
// mpx_stereo_decoder_pkg
//   Shared definitions for the MPX stereo decoder slice:
//   - FSM state encoding (IDLE / MUL38 / MUL19 / SUM)
//   - datapath widths (composite, reference, product, accumulator, output)
//   - demodulation / pilot scaling shifts and output saturation limits
//   - sat_out(): clamp a SUM_W-wide intermediate into the output range
package mpx_stereo_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL38,
    MUL19,
    SUM
  } state_t;

  localparam int unsigned MPX_W  = 20;
  localparam int unsigned REF_W  = 8;
  localparam int unsigned PROD_W = MPX_W + REF_W;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned OUT_W  = 18;
  // mpx + diff needs three guard bits over the composite width
  localparam int unsigned SUM_W  = MPX_W + 3;

  // diff = p38 >>> 6 carries the x2 demod gain; pilot term is scaled down by 2^7
  localparam int unsigned DEMOD_SHIFT = 6;
  localparam int unsigned PILOT_SHIFT = 7;

  localparam int OUT_MAX = int'(2 ** (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -int'(2 ** (OUT_W - 1));

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(OUT_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(OUT_MIN);

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI) begin
      return OUT_W'(SAT_HI);
    end else if (v < SAT_LO) begin
      return OUT_W'(SAT_LO);
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mpx_stereo_decoder_seqmult.sv
// mpx_seqmult
//   Signed shift-add multiplier, A_W x B_W, one multiplier bit per clock.
//   Ports:
//     clock, reset     system clock, async active-high reset
//     start            load a/b and begin a new product (overrides any in flight)
//     a, b             signed multiplicand / multiplier
//     ready            high during the cycle the final (sign) bit is processed
//     product          valid while ready is high (combinational final sum)
//   A product started in cycle 0 processes bits 0..B_W-1 in cycles 1..B_W and
//   presents the result with ready in cycle B_W, so a new start may be issued
//   in that same cycle without a gap.
module mpx_seqmult #(
  parameter int unsigned A_W = 20,
  parameter int unsigned B_W = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [A_W-1:0]       a,
  input  logic signed [B_W-1:0]       b,
  output logic                        ready,
  output logic signed [A_W+B_W-1:0]   product
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned IDX_W = $clog2(B_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B_W - 1);

  logic signed [P_W-1:0] a_sh;
  logic signed [P_W-1:0] acc;
  logic signed [P_W-1:0] pp;
  logic        [B_W-1:0] b_sh;
  logic        [IDX_W-1:0] idx;
  logic                  running;

  // Two's-complement multiplier: the MSB of b carries negative weight,
  // so its partial product is subtracted instead of added.
  always_comb begin
    pp      = b_sh[0] ? a_sh : '0;
    product = (idx == LAST_IDX) ? (acc - pp) : (acc + pp);
    ready   = running && (idx == LAST_IDX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      idx     <= '0;
      running <= 1'b0;
    end else if (start) begin
      a_sh    <= P_W'(a);
      b_sh    <= b;
      acc     <= '0;
      idx     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc  <= product;
      a_sh <= a_sh <<< 1;
      b_sh <= b_sh >> 1;
      idx  <= idx + IDX_W'(1);
      if (ready) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mpx_stereo_decoder.sv
// mpx_stereo_decoder
//   Recovers left/right audio from a 192 kHz composite (MPX) stream using
//   phase-aligned 38 kHz and 19 kHz reference sines, and flags pilot lock.
//   Ports:
//     clock, reset       system clock, async active-high reset
//     sample_en          one-cycle strobe: mpx_in/sine_38/sine_19 valid
//     mpx_in             signed composite sample
//     sine_38, sine_19   signed reference sines aligned with mpx_in
//     LO_LEFT, LO_RIGHT  signed recovered channels (held between updates)
//     out_valid          one-cycle pulse when LO_LEFT/LO_RIGHT update
//     stereo             pilot lock; selects stereo vs mono output
//     busy               sample in progress
//     overrun            sticky: a sample_en arrived while busy
//   Flow per sample: IDLE -> MUL38 (8 clk) -> MUL19 (8 clk) -> SUM (1 clk),
//   both products sharing one sequential multiplier; outputs appear 18 clocks
//   after the accepting cycle.
module mpx_stereo_decoder
  import mpx_stereo_decoder_pkg::*;
#(
  parameter int unsigned NBITS_MPX = MPX_W,
  parameter int unsigned NBITS_OUT = OUT_W,
  parameter int unsigned NBITS_REF = REF_W,
  parameter int unsigned PILOT_WIN = 192,
  parameter int unsigned PILOT_THR = 1000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sample_en,
  input  logic signed [NBITS_MPX-1:0] mpx_in,
  input  logic signed [NBITS_REF-1:0] sine_38,
  input  logic signed [NBITS_REF-1:0] sine_19,
  output logic signed [NBITS_OUT-1:0] LO_LEFT,
  output logic signed [NBITS_OUT-1:0] LO_RIGHT,
  output logic                        out_valid,
  output logic                        stereo,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned WIN_W = $clog2(PILOT_WIN);

  state_t state, state_next;

  logic signed [MPX_W-1:0]  mpx_q;
  logic signed [REF_W-1:0]  s19_q;
  logic signed [PROD_W-1:0] p38;
  logic signed [PROD_W-1:0] p19;

  logic                     mul_start;
  logic                     mul_ready;
  logic signed [MPX_W-1:0]  mul_a;
  logic signed [REF_W-1:0]  mul_b;
  logic signed [PROD_W-1:0] mul_product;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic        [ACC_W:0]    acc_mag;
  logic        [WIN_W-1:0]  win_cnt;
  logic                     win_end;
  logic                     lock_now;

  logic signed [SUM_W-1:0]  mpx_w;
  logic signed [SUM_W-1:0]  diff;
  logic signed [SUM_W-1:0]  sum_l;
  logic signed [SUM_W-1:0]  sum_r;
  logic signed [OUT_W-1:0]  left_next;
  logic signed [OUT_W-1:0]  right_next;

  // sine_38 is not held here: it goes straight into the multiplier, which
  // latches it on start. The 19 kHz product is started from the registered
  // copy in the same cycle the 38 kHz product completes.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    mul_a      = mpx_q;
    mul_b      = s19_q;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        mul_a = mpx_in;
        mul_b = sine_38;
        if (sample_en) begin
          mul_start  = 1'b1;
          state_next = MUL38;
        end
      end
      MUL38: begin
        if (mul_ready) begin
          mul_start  = 1'b1;
          state_next = MUL19;
        end
      end
      MUL19: begin
        if (mul_ready) begin
          state_next = SUM;
        end
      end
      SUM: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  mpx_seqmult #(
    .A_W (MPX_W),
    .B_W (REF_W)
  ) u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .ready   (mul_ready),
    .product (mul_product)
  );

  always_comb begin
    mpx_w      = SUM_W'(mpx_q);
    diff       = SUM_W'(p38 >>> DEMOD_SHIFT);
    sum_l      = (mpx_w + diff) >>> 1;
    sum_r      = (mpx_w - diff) >>> 1;
    left_next  = sat_out(mpx_w >>> 1);
    right_next = sat_out(mpx_w >>> 1);
    if (stereo) begin
      left_next  = sat_out(sum_l);
      right_next = sat_out(sum_r);
    end
    acc_next = acc + ACC_W'(p19 >>> PILOT_SHIFT);
    acc_mag  = acc_next[ACC_W-1] ? -{acc_next[ACC_W-1], acc_next} : {1'b0, acc_next};
    win_end  = (win_cnt == WIN_W'(PILOT_WIN - 1));
    lock_now = (acc_mag >= (ACC_W + 1)'(PILOT_THR));
  end

  // The output mux above reads the registered stereo flag, so a lock decision
  // made in this SUM cycle only affects the following sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mpx_q     <= '0;
      s19_q     <= '0;
      p38       <= '0;
      p19       <= '0;
      acc       <= '0;
      win_cnt   <= '0;
      LO_LEFT   <= '0;
      LO_RIGHT  <= '0;
      out_valid <= 1'b0;
      stereo    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_en && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sample_en) begin
            mpx_q <= mpx_in;
            s19_q <= sine_19;
          end
        end
        MUL38: begin
          if (mul_ready) begin
            p38 <= mul_product;
          end
        end
        MUL19: begin
          if (mul_ready) begin
            p19 <= mul_product;
          end
        end
        SUM: begin
          LO_LEFT   <= left_next;
          LO_RIGHT  <= right_next;
          out_valid <= 1'b1;
          if (win_end) begin
            stereo  <= lock_now;
            acc     <= '0;
            win_cnt <= '0;
          end else begin
            acc     <= acc_next;
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpx_stereo_decoder.sv
// tb_mpx_stereo_decoder
//   Self-checking bench for mpx_stereo_decoder. Expected outputs come from an
//   arithmetic reference model of the decoder's rules (products, scaling,
//   saturation, windowed pilot decision) evaluated per accepted sample.
module tb_mpx_stereo_decoder;

  localparam int WIN = 192;
  localparam int THR = 1000000;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               sample_en = 1'b0;
  logic signed [19:0] mpx_in = '0;
  logic signed [7:0]  sine_38 = '0;
  logic signed [7:0]  sine_19 = '0;
  logic signed [17:0] LO_LEFT;
  logic signed [17:0] LO_RIGHT;
  logic               out_valid;
  logic               stereo;
  logic               busy;
  logic               overrun;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_acc = 0;
  int m_cnt = 0;
  bit m_stereo = 1'b0;

  mpx_stereo_decoder #(
    .NBITS_MPX (20),
    .NBITS_OUT (18),
    .NBITS_REF (8),
    .PILOT_WIN (WIN),
    .PILOT_THR (THR)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .mpx_in    (mpx_in),
    .sine_38   (sine_38),
    .sine_19   (sine_19),
    .LO_LEFT   (LO_LEFT),
    .LO_RIGHT  (LO_RIGHT),
    .out_valid (out_valid),
    .stereo    (stereo),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic int sat18(input int v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_stereo = 1'b0;
  endtask

  // One accepted sample: outputs use the lock state before this sample,
  // then the pilot window advances and may update the lock state.
  task automatic model_step(input int mpx, input int s38, input int s19,
                            output int el, output int er, output bit est);
    int diff;
    diff = (mpx * s38) >>> 6;
    if (m_stereo) begin
      el = sat18((mpx + diff) >>> 1);
      er = sat18((mpx - diff) >>> 1);
    end else begin
      el = sat18(mpx >>> 1);
      er = el;
    end
    m_acc += (mpx * s19) >>> 7;
    m_cnt++;
    if (m_cnt == WIN) begin
      m_stereo = ((m_acc < 0) ? -m_acc : m_acc) >= THR;
      m_acc = 0;
      m_cnt = 0;
    end
    est = m_stereo;
  endtask

  task automatic drive(input int mpx, input int s38, input int s19);
    mpx_in    = 20'(mpx);
    sine_38   = 8'(s38);
    sine_19   = 8'(s19);
    sample_en = 1'b1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Full transaction: accept, latency, outputs, then one-cycle pulse / hold.
  task automatic do_sample(input string tag, input int mpx, input int s38, input int s19);
    int el, er, cyc;
    bit est;
    model_step(mpx, s38, s19, el, er, est);
    drive(mpx, s38, s19);
    @(posedge clock);
    #1 sample_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: got %b expected 1", tag, busy);
    end
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL %s latency: out_valid in cycle %0d expected 18", tag, cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_valid: got %b expected 0", tag, busy);
    end
    checks++;
    if (int'(LO_LEFT) != el) begin
      errors++;
      $display("FAIL %s LO_LEFT: got %0d expected %0d (mpx=%0d s38=%0d s19=%0d)", tag, LO_LEFT, el, mpx, s38, s19);
    end
    checks++;
    if (int'(LO_RIGHT) != er) begin
      errors++;
      $display("FAIL %s LO_RIGHT: got %0d expected %0d (mpx=%0d s38=%0d s19=%0d)", tag, LO_RIGHT, er, mpx, s38, s19);
    end
    checks++;
    if (stereo !== est) begin
      errors++;
      $display("FAIL %s stereo: got %b expected %b", tag, stereo, est);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || int'(LO_LEFT) != el || int'(LO_RIGHT) != er || stereo !== est) begin
      errors++;
      $display("FAIL %s hold: out_valid=%b L=%0d R=%0d stereo=%b expected 0 %0d %0d %b",
               tag, out_valid, LO_LEFT, LO_RIGHT, stereo, el, er, est);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (LO_LEFT !== '0 || LO_RIGHT !== '0) begin
      errors++;
      $display("FAIL reset_outputs: L=%0d R=%0d expected 0 0", LO_LEFT, LO_RIGHT);
    end
    checks++;
    if (out_valid !== 1'b0 || stereo !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b stereo=%b busy=%b overrun=%b expected 0000",
               out_valid, stereo, busy, overrun);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_mono();
    do_sample("mono", 1000, 64, 0);
  endtask

  task automatic test_overrun();
    int el, er, cyc, pulses;
    bit est;
    model_step(1000, 64, 0, el, er, est);
    drive(1000, 64, 0);
    @(posedge clock);
    #1 sample_en = 1'b0;
    cyc = 1;
    repeat (4) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_before: got %b expected 0", overrun);
    end
    drive(9999, 64, 0);
    @(posedge clock);
    #1 sample_en = 1'b0;
    cyc++;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL overrun_latency: out_valid in cycle %0d expected 18", cyc);
    end
    checks++;
    if (int'(LO_LEFT) != el || int'(LO_RIGHT) != er) begin
      errors++;
      $display("FAIL overrun_outputs: L=%0d R=%0d expected %0d %0d", LO_LEFT, LO_RIGHT, el, er);
    end
    pulses = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL overrun_no_second_valid: got %0d pulses expected 0", pulses);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_midflight();
    int pulses;
    drive(3000, 5, 3);
    @(posedge clock);
    #1 sample_en = 1'b0;
    repeat (11) begin
      @(posedge clock);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (LO_LEFT !== '0 || LO_RIGHT !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: L=%0d R=%0d expected 0 0", LO_LEFT, LO_RIGHT);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy: got %b expected 0", busy);
    end
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b0 || stereo !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: overrun=%b valid=%b stereo=%b expected 000", overrun, out_valid, stereo);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    pulses = 0;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midreset_no_valid: got %0d pulses expected 0", pulses);
    end
    do_sample("post_reset", -777, 12, 0);
  endtask

  task automatic test_back_to_back();
    int ela, era, elc, erc, cyc;
    bit esa, esc;
    model_step(2500, 30, -20, ela, era, esa);
    drive(2500, 30, -20);
    @(posedge clock);
    #1 sample_en = 1'b0;
    repeat (16) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sum_cycle: valid=%b busy=%b expected 0 1", out_valid, busy);
    end
    // offered during SUM: must be dropped
    drive(1111, 100, 100);
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b1 || int'(LO_LEFT) != ela || int'(LO_RIGHT) != era) begin
      errors++;
      $display("FAIL b2b_first: valid=%b L=%0d R=%0d expected 1 %0d %0d", out_valid, LO_LEFT, LO_RIGHT, ela, era);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sum_drop_overrun: got %b expected 1", overrun);
    end
    // offered in the out_valid cycle: FSM is idle, must be accepted
    model_step(-4000, -7, 9, elc, erc, esc);
    drive(-4000, -7, 9);
    @(posedge clock);
    #1 sample_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL b2b_latency: out_valid in cycle %0d expected 18", cyc);
    end
    checks++;
    if (int'(LO_LEFT) != elc || int'(LO_RIGHT) != erc || stereo !== esc) begin
      errors++;
      $display("FAIL b2b_second: L=%0d R=%0d stereo=%b expected %0d %0d %b",
               LO_LEFT, LO_RIGHT, stereo, elc, erc, esc);
    end
  endtask

  task automatic test_pilot_nolock();
    pulse_reset();
    for (int i = 0; i < WIN; i++) begin
      do_sample("pilot_nolock", 0, 0, 127);
    end
    checks++;
    if (stereo !== 1'b0) begin
      errors++;
      $display("FAIL pilot_nolock_final: stereo=%b expected 0", stereo);
    end
  endtask

  task automatic test_pilot_lock();
    for (int i = 0; i < WIN; i++) begin
      do_sample("pilot_lock", 40000, 0, 127);
    end
    checks++;
    if (stereo !== 1'b1) begin
      errors++;
      $display("FAIL pilot_lock_final: stereo=%b expected 1", stereo);
    end
  endtask

  task automatic test_stereo_decode();
    do_sample("stereo_decode", 1000, -128, 0);
  endtask

  task automatic test_saturation();
    do_sample("sat_pos", 524287, 127, 0);
    do_sample("sat_neg", -524288, 127, 0);
  endtask

  task automatic test_random();
    logic signed [19:0] r20;
    logic signed [7:0]  r38;
    logic signed [7:0]  r19;
    int mpx;
    for (int i = 0; i < 150; i++) begin
      r20 = 20'($urandom);
      r38 = 8'($urandom);
      r19 = 8'($urandom);
      mpx = int'(r20);
      if ($urandom_range(0, 9) == 0) mpx = ($urandom_range(0, 1) == 1) ? 524287 : -524288;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      do_sample("random", mpx, int'(r38), int'(r19));
    end
  endtask

  initial begin
    test_reset();
    test_mono();
    test_overrun();
    test_reset_midflight();
    test_back_to_back();
    test_pilot_nolock();
    test_pilot_lock();
    test_stereo_decode();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
